// File: rtl/posit_pkg.sv
// posit_pkg: shared posit constants, regime-length helper and result-field struct.
package posit_pkg;
  localparam int DEF_N = 32;
  localparam int DEF_ES = 2;
  localparam int DEF_RS = $clog2(DEF_N);
  typedef struct packed {
    logic sign;
    logic signed [DEF_RS:0] k;
    logic [DEF_ES-1:0] exp;
    logic [DEF_N-1:0] mant;
    logic inf;
    logic zero;
  } posit_fields_t;
  function automatic logic [63:0] posit_nar(int n);
    return 64'd1 << (n - 1);
  endfunction
  function automatic logic [63:0] posit_zero(int n);
    return 64'd0 & 64'(n);
  endfunction
  function automatic logic [63:0] posit_maxpos(int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] posit_minpos(int n);
    return 64'd1 | (64'd0 & 64'(n));
  endfunction
  function automatic int regime_len(int k);
    return k >= 0 ? k + 2 : 1 - k;
  endfunction
endpackage

// File: rtl/posit_round_rne.sv
// posit_round_rne: round-to-nearest-even increment of an N-1 bit magnitude, clamped at maxpos.
module posit_round_rne import posit_pkg::*; #(
  parameter int N = 32
) (
  input  logic [N-2:0] m,
  input  logic         guard,
  input  logic         sticky,
  output logic [N-2:0] r
);
  logic [N-1:0] sum;
  assign sum = {1'b0, m} + N'(guard & (sticky | m[0]));
  assign r = sum[N-1] ? '1 : sum[N-2:0];
endmodule

// File: rtl/posit_construct_round.sv
// posit_construct_round: two-stage valid/ready encoder turning normalised fields into an RNE-rounded posit.
module posit_construct_round import posit_pkg::*; #(
  parameter int N = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic signed [RS:0]         in_k,
  input  logic [(ES>0?ES:1)-1:0]     in_exp,
  input  logic [N-1:0]               in_mant,
  input  logic                       in_inf,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_posit
);
  localparam logic [N-1:0] NAR = N'(posit_nar(N));
  localparam logic [N-1:0] ZERO = N'(posit_zero(N));
  localparam logic [N-1:0] MAXPOS = N'(posit_maxpos(N));
  localparam logic [N-1:0] MINPOS = N'(posit_minpos(N));
  localparam logic [2*N-1:0] ONES = '1;
  localparam logic [2*N-1:0] TOP = {1'b1, {(2*N-1){1'b0}}};
  logic s1_valid, s2_valid, adv1, adv2;
  logic s1_sign, s1_inf, s1_zero, s1_smax, s1_smin;
  logic [2*N-1:0] s1_str, str, regime;
  logic [ES+N-2:0] body;
  logic smax, smin;
  int kv, len;
  logic [N-2:0] rounded, mag;
  logic [N-1:0] signed_mag, result;
  logic unused;
  assign unused = ^{in_mant[N-1], in_exp};
  if (ES > 0) begin : g_exp
    assign body = {in_exp[ES-1:0], in_mant[N-2:0]};
  end else begin : g_noexp
    assign body = in_mant[N-2:0];
  end
  assign adv2 = !s2_valid || out_ready;
  assign adv1 = !s1_valid || adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid;
  always_comb begin
    kv = int'(in_k);
    len = regime_len(kv);
    smax = kv >= N - 2;
    smin = kv <= -(N - 2);
    regime = kv >= 0 ? ~(ONES >> (kv + 1)) : (TOP >> (-kv));
    str = regime | ({body, {(N-ES+1){1'b0}}} >> len);
  end
  posit_round_rne #(.N(N)) u_rnd (
    .m(s1_str[2*N-1:N+1]),
    .guard(s1_str[N]),
    .sticky(|s1_str[N-1:0]),
    .r(rounded)
  );
  // a non-zero value that rounds to nothing becomes minpos, never zero
  assign mag = s1_smax ? MAXPOS[N-2:0] : (s1_smin || rounded == '0) ? MINPOS[N-2:0] : rounded;
  assign signed_mag = s1_sign ? -{1'b0, mag} : {1'b0, mag};
  assign result = s1_inf ? NAR : s1_zero ? ZERO : signed_mag;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_posit <= '0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv1 && in_valid) begin
        s1_str <= str;
        s1_sign <= in_sign;
        s1_inf <= in_inf;
        s1_zero <= in_zero;
        s1_smax <= smax;
        s1_smin <= smin;
      end
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) out_posit <= result;
    end
  end
endmodule

// File: tb/tb_posit_construct_round.sv
// tb_posit_construct_round: directed checks of the posit encoder at N=8/ES=0 and N=32/ES=2.
module tb_posit_construct_round;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic iv, ir, s, inf, zero, ov, ordy;
  logic signed [3:0] k;
  logic [0:0] ex;
  logic [7:0] mant, po;
  logic iv32, ir32, ov32, s32, inf32, zero32;
  logic signed [5:0] k32;
  logic [1:0] ex32;
  logic [31:0] mant32, po32;
  int checks = 0, errors = 0;

  posit_construct_round #(.N(8), .ES(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_sign(s), .in_k(k),
    .in_exp(ex), .in_mant(mant), .in_inf(inf), .in_zero(zero), .out_valid(ov),
    .out_ready(ordy), .out_posit(po)
  );
  posit_construct_round #(.N(32), .ES(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in_sign(s32), .in_k(k32),
    .in_exp(ex32), .in_mant(mant32), .in_inf(inf32), .in_zero(zero32), .out_valid(ov32),
    .out_ready(1'b1), .out_posit(po32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run8(input string tag, input logic sg, input logic signed [3:0] kk,
                      input logic [7:0] mm, input logic fi, input logic fz, input logic [7:0] want);
    int lat;
    s = sg; k = kk; mant = mm; inf = fi; zero = fz; iv = 1'b1;
    check({tag, "_rdy"}, 32'(ir), 32'd1);
    @(posedge clk); #1 iv = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov && lat < 10);
    check({tag, "_lat"}, lat, 2);
    check(tag, 32'(po), 32'(want));
    @(posedge clk); #1;
  endtask

  logic bq_s[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic signed [3:0] bq_k[4] = '{4'sd0, 4'sd0, 4'sd0, 4'sd7};
  logic [7:0] bq_m[4] = '{8'h80, 8'hC0, 8'h80, 8'h80};
  logic [7:0] bq_exp[4] = '{8'h40, 8'h50, 8'hC0, 8'h7F};

  initial begin
    int sent, got, cyc, lat;
    logic rdy, held_v;
    logic [7:0] held;
    rst_n = 1'b0; ordy = 1'b1; iv = 1'b0; s = 1'b0; k = '0; ex = '0; mant = '0; inf = 1'b0; zero = 1'b0;
    iv32 = 1'b0; s32 = 1'b0; k32 = '0; ex32 = '0; mant32 = '0; inf32 = 1'b0; zero32 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_out_posit", 32'(po), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(ir), 32'd1);
    @(posedge clk); #1;

    run8("k0_pos", 1'b0, 4'sd0, 8'h80, 1'b0, 1'b0, 8'h40);
    run8("k0_neg", 1'b1, 4'sd0, 8'h80, 1'b0, 1'b0, 8'hC0);
    run8("k0_frac", 1'b0, 4'sd0, 8'hC0, 1'b0, 1'b0, 8'h50);
    run8("tie_odd", 1'b0, 4'sd0, 8'h86, 1'b0, 1'b0, 8'h42);
    run8("sat_max", 1'b0, 4'sd7, 8'h80, 1'b0, 1'b0, 8'h7F);
    run8("sat_min", 1'b0, -4'sd7, 8'h80, 1'b0, 1'b0, 8'h01);
    run8("carry", 1'b0, 4'sd5, 8'hFF, 1'b0, 1'b0, 8'h7F);
    run8("sat_neg", 1'b1, 4'sd7, 8'h80, 1'b0, 1'b0, 8'h81);
    run8("nar", 1'b1, -4'sd3, 8'hA5, 1'b1, 1'b0, 8'h80);
    run8("zero", 1'b1, 4'sd2, 8'hC0, 1'b0, 1'b1, 8'h00);
    run8("nar_zero", 1'b0, 4'sd1, 8'h80, 1'b1, 1'b1, 8'h80);

    sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
    ordy = 1'b0; iv = 1'b1; inf = 1'b0; zero = 1'b0;
    s = bq_s[0]; k = bq_k[0]; mant = bq_m[0];
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      rdy = ir;
      if (cyc == 2) check("bp_in_ready_drop", 32'(ir), 32'd0);
      if (held_v && ov) check("bp_hold", 32'(po), 32'(held));
      held_v = ov && !ordy;
      held = po;
      if (ov && ordy) begin
        check($sformatf("bp_out%0d", got), 32'(po), 32'(bq_exp[got]));
        got++;
      end
      @(posedge clk); #1;
      if (iv && rdy) sent++;
      iv = sent < 4;
      if (sent < 4) begin
        s = bq_s[sent]; k = bq_k[sent]; mant = bq_m[sent];
      end
      cyc++;
      ordy = cyc >= 3;
    end
    check("bp_count", got, 4);
    repeat (3) begin
      @(negedge clk);
      check("bp_no_dup", 32'(ov), 32'd0);
    end

    @(posedge clk); #1;
    ordy = 1'b0; s = 1'b0; k = 4'sd0; mant = 8'h80; iv = 1'b1;
    @(posedge clk); #1 mant = 8'hC0;
    @(posedge clk); #1 iv = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; ordy = 1'b1;
    @(negedge clk);
    check("rst_flush", 32'(ov), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_stale", 32'(ov), 32'd0);
    end

    @(posedge clk); #1;
    k32 = 6'sd0; ex32 = 2'd0; mant32 = 32'h8000_0000; iv32 = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov32 && lat < 10);
    check("n32_lat", lat, 2);
    check("n32_k0", po32, 32'h4000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
